// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_pkg
//  Purpose  : Shared types and constants for the memory-mapped UART
//             transmitter (mmio_uart_tx) and its helpers.
//  Contents : state_t serialiser states, register word offsets, STATUS bit
//             positions, BAUDDIV sanitising helper.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  // Serialiser states. PARITY is only reachable when UART_TX_PARITY_EN is set.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Register word offsets (DataAdr[3:2]).
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

  // STATUS bit positions.
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_PAR     = 4;
  localparam int STAT_CNT_LSB = 8;

  // A divider of zero would stall the bit timer, so it is stored as 1.
  function automatic logic [15:0] sanitize_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO. dout always shows the
//             oldest entry while the FIFO is non-empty.
//  Ports    : clk, reset (async, active-low)
//             push/din  - write an entry (ignored when full unless popping)
//             pop       - discard the head entry (ignored when empty)
//             dout      - head entry
//             full, empty, count ($clog2(DEPTH)+1 bits)
//  Params   : WIDTH entry width, DEPTH entries (power of 2, >= 2)
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the same cycle frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so incrementing wraps modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx
//  Purpose  : Memory-mapped 8N1 UART transmitter on the processor data bus.
//             Written bytes are queued in a FIFO and shifted out LSB first.
//  Ports    : clk        system clock
//             reset      asynchronous, active-low reset
//             DataAdr    bus address
//             WriteData  bus write data
//             MemWrite   write strobe (takes effect at rising clk)
//             ReadData   combinational read data, 0 when not addressed
//             tx         serial output, idle high
//             tx_busy    frame on the line or FIFO non-empty
//  Map      : +0x0 TXDATA (W)  +0x4 STATUS (R; W clears overflow)
//             +0x8 BAUDDIV (RW, 0 stored as 1)  +0xC reserved
//  Config   : UART_TX_PARITY_EN - adds an even parity bit after the data
//             bits and sets STATUS[4].
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  logic       sel;
  logic [1:0] off;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_baud;
  logic       unused_bus_bits;

  assign sel       = (DataAdr[31:4] == BASE_ADDR[31:4]);
  assign off       = DataAdr[3:2];
  assign wr_txdata = sel & MemWrite & (off == OFF_TXDATA);
  assign wr_status = sel & MemWrite & (off == OFF_STATUS);
  assign wr_baud   = sel & MemWrite & (off == OFF_BAUDDIV);

  // Byte lanes and upper write bits carry no meaning for this block.
  assign unused_bus_bits = ^{DataAdr[1:0], WriteData[31:16]};

  // ------------------------------------------------------------------ FIFO
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // -------------------------------------------------------- register file
  logic [15:0] baud_div;
  logic        overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_div <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= sanitize_div(WriteData[15:0]);
      // A push that coincides with a pop into a full FIFO is not an overflow.
      if (wr_status)
        overflow <= 1'b0;
      else if (wr_txdata & fifo_full & ~fifo_pop)
        overflow <= 1'b1;
    end
  end

  // ------------------------------------------------------------ serialiser
  state_t      state,   state_n;
  logic [15:0] div_q,   div_q_n;
  logic [15:0] cnt,     cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg,   shreg_n;
  logic        load;
`ifdef UART_TX_PARITY_EN
  logic        par_bit, par_n;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      div_q   <= DEFAULT_DIV;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      div_q   <= div_q_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
`ifdef UART_TX_PARITY_EN
      par_bit <= par_n;
`endif
    end
  end

  // Each state lasts div_q clocks: the timer is loaded with div_q-1 on entry
  // and the state advances on the cycle the timer reads 0.
  always_comb begin
    state_n   = state;
    div_q_n   = div_q;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
`ifdef UART_TX_PARITY_EN
    par_n     = par_bit;
`endif
    fifo_pop  = 1'b0;
    load      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (cnt == 16'd0) begin
          state_n   = ST_DATA;
          cnt_n     = div_q - 16'd1;
          bit_idx_n = 3'd0;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt == 16'd0) begin
          cnt_n   = div_q - 16'd1;
          shreg_n = shreg >> 1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt == 16'd0) begin
          state_n = ST_STOP;
          cnt_n   = div_q - 16'd1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt == 16'd0) begin
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) load = 1'b1;
          else             state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Frame setup: BAUDDIV is sampled here, so later writes wait a frame.
    if (load) begin
      fifo_pop = 1'b1;
      shreg_n  = fifo_dout;
      div_q_n  = baud_div;
      cnt_n    = baud_div - 16'd1;
      state_n  = ST_START;
`ifdef UART_TX_PARITY_EN
      par_n    = ^fifo_dout;
`endif
    end
  end

  // tx is decoded from reset-cleared state, so reset drives it high at once.
  always_comb begin
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shreg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx = par_bit;
`endif
      default:  tx = 1'b1;
    endcase
  end

  assign tx_busy = (state != ST_IDLE) | ~fifo_empty;

  // ------------------------------------------------------------ read mux
  always_comb begin
    ReadData = '0;
    if (sel) begin
      case (off)
        OFF_STATUS: begin
          ReadData[STAT_FULL]  = fifo_full;
          ReadData[STAT_EMPTY] = fifo_empty;
          ReadData[STAT_BUSY]  = tx_busy;
          ReadData[STAT_OVF]   = overflow;
`ifdef UART_TX_PARITY_EN
          ReadData[STAT_PAR]   = 1'b1;
`endif
          ReadData[STAT_CNT_LSB +: CW] = fifo_count;
        end
        OFF_BAUDDIV: ReadData[15:0] = baud_div;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mmio_uart_tx
//  Purpose  : Self-checking bench for mmio_uart_tx. Stimulus queues expected
//             frames and read values; independent monitors decode tx and
//             sample ReadData and compare against those queues.
//  Config   : honours UART_TX_PARITY_EN (frame length, parity bit, STATUS[4]).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          DIV0 = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS    = 11;
  localparam logic [31:0] PAR_FLAG = 32'h10;
`else
  localparam int          NBITS    = 10;
  localparam logic [31:0] PAR_FLAG = 32'h0;
`endif

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         b2b;
    bit         abort;
  } frame_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic        tx;
  logic        tx_busy;
  logic        rd_strobe = 1'b0;

  int     checks = 0;
  int     errors = 0;
  int     pending = 0;
  int     cyc = 0;
  frame_t exp_q[$];
  rd_t    rd_q[$];

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'(DIV0))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // All bus tasks are entered 1 ns after a rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    DataAdr = a; WriteData = d; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd_t r;
    r.name = name; r.val = exp;
    rd_q.push_back(r);
    DataAdr = a; MemWrite = 1'b0; rd_strobe = 1'b1;
    @(posedge clk); #1;
    rd_strobe = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int dv, input bit b2b, input bit ab);
    frame_t f;
    f.data = d; f.div = dv; f.b2b = b2b; f.abort = ab;
    exp_q.push_back(f);
    pending++;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((pending != 0 || tx_busy !== 1'b0) && n < max_cyc) begin
      @(posedge clk); n++;
    end
    #1;
    chk({name, "_pending"}, pending, 0);
    chk({name, "_idle"}, {31'd0, tx_busy}, 32'd0);
  endtask

  // ---------------------------------------------------------- read monitor
  initial begin : rd_monitor
    rd_t r;
    forever begin
      @(negedge clk);
      if (rd_strobe) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: read with no expected value (cycle %0d)", cyc);
        end else begin
          r = rd_q.pop_front();
          chk(r.name, ReadData, r.val);
        end
      end
    end
  end

  // ------------------------------------------------------------ tx monitor
  initial begin : tx_monitor
    frame_t             e;
    logic [NBITS-1:0]   bits;
    int                 pos, tgt, st, n;
    int                 prev_start;
    int                 prev_len;
    bit                 seen;
    prev_start = -100000;
    prev_len   = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        st = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: start bit with no queued frame (cycle %0d)", cyc);
          n = 0;
          while (tx !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        end else begin
          e = exp_q.pop_front();
          if (e.abort) begin
            seen = 1'b0;
            for (int k = 0; k < 400 && !seen; k++) begin
              @(negedge clk);
              if (reset === 1'b0) begin
                seen = 1'b1;
                chk("abort_tx_high", {31'd0, tx}, 32'd1);
              end
            end
            if (!seen) begin
              checks++; errors++;
              $display("FAIL abort_timeout: reset never seen during frame (cycle %0d)", cyc);
            end
          end else begin
            if (e.b2b) chk("b2b_start_cycle", st, prev_start + prev_len);
            pos = 0;
            for (int j = 0; j < NBITS; j++) begin
              tgt = j * e.div + e.div / 2;
              repeat (tgt - pos) @(negedge clk);
              pos = tgt;
              bits[j] = tx;
            end
            chk("start_bit", {31'd0, bits[0]}, 32'd0);
            chk("data_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", {31'd0, bits[9]}, {31'd0, ^e.data});
`endif
            chk("stop_bit", {31'd0, bits[NBITS-1]}, 32'd1);
            prev_start = st;
            prev_len   = NBITS * e.div;
          end
          pending--;
        end
      end
    end
  end

  // ------------------------------------------------------------- watchdog
  initial begin : watchdog
    #200_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------- stimulus
  initial begin : stimulus
    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, tx_busy}, 32'd0);
    reset = 1'b1;
    bus_read("reset_status", BASE + 32'h4, 32'h0000_0002 | PAR_FLAG);
    bus_read("reset_bauddiv", BASE + 32'h8, 32'(DIV0));
    bus_read("txdata_reads_zero", BASE + 32'h0, 32'h0);

    // 1: single byte 0x55, busy drops 40 clocks after the pop
    expect_frame(8'h55, DIV0, 1'b0, 1'b0);
    bus_write(BASE, 32'h55);
    chk("t1_busy_after_write", {31'd0, tx_busy}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("t1_busy_last_stop_clk", {31'd0, tx_busy}, 32'd1);
    @(posedge clk); #1;
    chk("t1_busy_done", {31'd0, tx_busy}, 32'd0);
    wait_drain("t1", 200);

    // 2: fill to exactly full, then overflow, then clear
    for (int i = 1; i <= 9; i++) begin
      expect_frame(8'(i), DIV0, (i != 1), 1'b0);
      bus_write(BASE, 32'(i));
    end
    bus_read("t2_status_full", BASE + 32'h4, 32'h0000_0805 | PAR_FLAG);
    for (int i = 0; i < 9; i++) bus_write(BASE, 32'hE0 + 32'(i));
    bus_read("t2_status_ovf", BASE + 32'h4, 32'h0000_080D | PAR_FLAG);
    bus_write(BASE + 32'h4, 32'h0);
    bus_read("t2_status_ovf_clr", BASE + 32'h4, 32'h0000_0805 | PAR_FLAG);
    wait_drain("t2", 800);

    // 3: two queued bytes go out back-to-back
    expect_frame(8'hA5, DIV0, 1'b0, 1'b0);
    expect_frame(8'h3C, DIV0, 1'b1, 1'b0);
    bus_write(BASE, 32'hA5);
    bus_write(BASE, 32'h3C);
    wait_drain("t3", 200);

    // 4: BAUDDIV 0 -> 1; mid-frame change applies to the next frame only
    bus_write(BASE + 32'h8, 32'h0);
    bus_read("t4_baud_zero_to_one", BASE + 32'h8, 32'h1);
    bus_write(BASE + 32'h8, 32'(DIV0));
    expect_frame(8'h81, DIV0, 1'b0, 1'b0);
    expect_frame(8'h42, 8, 1'b1, 1'b0);
    bus_write(BASE, 32'h81);
    repeat (6) @(posedge clk);
    #1;
    bus_write(BASE + 32'h8, 32'h8);
    bus_read("t4_baud_eight", BASE + 32'h8, 32'h8);
    bus_write(BASE, 32'h42);
    wait_drain("t4", 300);

    // 5: reset in the middle of the data bits
    bus_write(BASE + 32'h8, 32'(DIV0));
    expect_frame(8'h00, DIV0, 1'b0, 1'b1);
    bus_write(BASE, 32'h00);
    bus_write(BASE, 32'h11);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_tx_low_in_data", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    chk("t5_tx_high_on_reset", {31'd0, tx}, 32'd1);
    chk("t5_busy_clear_on_reset", {31'd0, tx_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus_read("t5_status_empty", BASE + 32'h4, 32'h0000_0002 | PAR_FLAG);
    bus_read("t5_baud_default", BASE + 32'h8, 32'(DIV0));
    bus_read("t5_out_of_range", BASE + 32'h10, 32'h0);
    bus_read("t5_below_range", BASE - 32'h4, 32'h0);
    bus_write(BASE + 32'h10, 32'h99);
    bus_write(BASE + 32'hC, 32'hFFFF);
    bus_read("t5_reserved_reads_zero", BASE + 32'hC, 32'h0);
    bus_read("t5_byte_lane_ignored", BASE + 32'h9, 32'(DIV0));
    bus_read("t5_no_push_from_outside", BASE + 32'h4, 32'h0000_0002 | PAR_FLAG);
    repeat (60) @(posedge clk);
    #1;
    chk("t5_no_stray_frame", pending, 0);

    // 6: 0x07 (odd weight, parity bit 1 when enabled) chained to 0x01
    expect_frame(8'h07, DIV0, 1'b0, 1'b0);
    expect_frame(8'h01, DIV0, 1'b1, 1'b0);
    bus_write(BASE, 32'h07);
    bus_write(BASE, 32'h01);
    wait_drain("t6", 300);

    repeat (20) @(posedge clk);
    #1;
    chk("final_rd_queue", rd_q.size(), 0);
    chk("final_frame_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
